// File: rtl/bf_window_monitor.sv
// bf_window_monitor: per-channel bit-flip hit/popcount monitor over a programmable window.
// Define BF_MAXBURST_EN to add per-channel maximum consecutive-hit burst tracking.
module bf_window_monitor #(
   parameter int NUM_CH     = 4,
   parameter int CH_WIDTH   = 32,
   parameter int CNT_WIDTH  = 24,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic [NUM_CH*CH_WIDTH-1:0] value_i,
   input  logic                       reg_valid_i,
   input  logic                       reg_write_i,
   input  logic [ADDR_WIDTH-1:0]      reg_addr_i,
   input  logic [DATA_WIDTH-1:0]      reg_wdata_i,
   output logic [DATA_WIDTH-1:0]      reg_rdata_o,
   output logic                       reg_ready_o,
   output logic                       reg_error_o,
   output logic                       irq_o
);
   localparam int PCW  = $clog2(CH_WIDTH + 1);
   localparam int SW   = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
   localparam int NREG = 8 + 4 * NUM_CH;

   localparam logic [CNT_WIDTH-1:0]  CMAX  = '1;
   localparam logic [CNT_WIDTH-1:0]  C_ONE = 1;
   localparam logic [DATA_WIDTH-1:0] D_ONE = 1;
   localparam logic [DATA_WIDTH-1:0] ERR_W = DATA_WIDTH'(32'hDEADBEEF);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic [NUM_CH*CH_WIDTH-1:0] r_input_q;
   logic [1:0]                 r_state;
   logic                       r_en;
   logic [DATA_WIDTH-1:0]      r_window;
   logic [DATA_WIDTH-1:0]      r_shadow;
   logic [DATA_WIDTH-1:0]      r_wcnt;
   logic [DATA_WIDTH-1:0]      r_thresh;
   logic [NUM_CH-1:0]          r_irq_en;
   logic [NUM_CH-1:0]          r_irq_status;
   logic [CNT_WIDTH-1:0]       r_win_count;
   logic [CNT_WIDTH-1:0]       r_hit_acc [NUM_CH];
   logic [CNT_WIDTH-1:0]       r_bit_acc [NUM_CH];
   logic [CNT_WIDTH-1:0]       r_hits    [NUM_CH];
   logic [CNT_WIDTH-1:0]       r_bits    [NUM_CH];
   logic [DATA_WIDTH-1:0]      r_rdata;
   logic                       r_ready;
   logic                       r_error;
   logic                       r_irq;

   logic                       w_acc;
   logic                       w_wr;
   logic                       w_sclr;
   logic                       w_wend;
   logic                       w_err;
   logic [DATA_WIDTH-1:0]      w_rd;
   logic [DATA_WIDTH-1:0]      w_win_eff;
   logic [ADDR_WIDTH-1:0]      w_off;
   logic [NUM_CH-1:0]          w_hit;
   logic [NUM_CH-1:0]          w_over;
   logic [NUM_CH-1:0]          w_set;
   logic [NUM_CH-1:0]          w_w1c;
   logic [CNT_WIDTH-1:0]       w_hit_nx [NUM_CH];
   logic [CNT_WIDTH-1:0]       w_bit_nx [NUM_CH];

   function automatic logic [SW-1:0] popcnt(input logic [CH_WIDTH-1:0] v);
      logic [SW-1:0] n;
      n = '0;
      for (int i = 0; i < CH_WIDTH; i++) n = n + SW'(v[i]);
      return n;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat(input logic [SW-1:0] s);
      return (s > SW'(CMAX)) ? CMAX : s[CNT_WIDTH-1:0];
   endfunction

   assign reg_rdata_o = r_rdata;
   assign reg_ready_o = r_ready;
   assign reg_error_o = r_error;
   assign irq_o       = r_irq;

   assign w_acc     = reg_valid_i && !r_ready;
   assign w_wr      = w_acc && reg_write_i && !w_err;
   assign w_sclr    = w_wr && (reg_addr_i == ADDR_WIDTH'(0)) && reg_wdata_i[1];
   assign w_win_eff = (r_window == '0) ? D_ONE : r_window;
   assign w_wend    = (r_state == S_RUN) && r_en && (r_wcnt == r_shadow - D_ONE);
   assign w_set     = w_wend ? w_over : '0;
   assign w_w1c     = (w_wr && (reg_addr_i == ADDR_WIDTH'(4))) ?
                      reg_wdata_i[NUM_CH-1:0] : '0;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         w_hit[c]    = |r_input_q[c*CH_WIDTH +: CH_WIDTH];
         w_hit_nx[c] = sat(SW'(r_hit_acc[c]) + SW'(w_hit[c]));
         w_bit_nx[c] = sat(SW'(r_bit_acc[c]) +
                           popcnt(r_input_q[c*CH_WIDTH +: CH_WIDTH]));
         w_over[c]   = DATA_WIDTH'(w_hit_nx[c]) > r_thresh;
      end
   end

`ifdef BF_MAXBURST_EN
   logic [CNT_WIDTH-1:0] r_run    [NUM_CH];
   logic [CNT_WIDTH-1:0] r_max    [NUM_CH];
   logic [CNT_WIDTH-1:0] r_mb     [NUM_CH];
   logic [CNT_WIDTH-1:0] w_run_nx [NUM_CH];
   logic [CNT_WIDTH-1:0] w_max_nx [NUM_CH];

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         w_run_nx[c] = !w_hit[c] ? '0 :
                       (r_run[c] == CMAX) ? CMAX : r_run[c] + C_ONE;
         w_max_nx[c] = (w_run_nx[c] > r_max[c]) ? w_run_nx[c] : r_max[c];
      end
   end

   // Runs never span a window boundary or an ARM restart.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_run[c] <= '0;
            r_max[c] <= '0;
            r_mb[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_sclr) begin
               r_run[c] <= '0;
               r_max[c] <= '0;
               r_mb[c]  <= '0;
            end else if (r_state == S_ARM) begin
               r_run[c] <= '0;
               r_max[c] <= '0;
            end else if (w_wend) begin
               r_mb[c]  <= w_max_nx[c];
               r_run[c] <= '0;
               r_max[c] <= '0;
            end else if ((r_state == S_RUN) && r_en) begin
               r_run[c] <= w_run_nx[c];
               r_max[c] <= w_max_nx[c];
            end
         end
      end
   end
`endif

   always_comb begin
      w_rd  = '0;
      w_err = 1'b0;
      w_off = reg_addr_i - ADDR_WIDTH'(8);
      if (int'(reg_addr_i) >= NREG) begin
         w_err = 1'b1;
      end else if (int'(reg_addr_i) >= 8) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (int'(w_off[ADDR_WIDTH-1:2]) == c) begin
               case (w_off[1:0])
                  2'd0:    w_rd = DATA_WIDTH'(r_hits[c]);
                  2'd1:    w_rd = DATA_WIDTH'(r_bits[c]);
`ifdef BF_MAXBURST_EN
                  2'd2:    w_rd = DATA_WIDTH'(r_mb[c]);
`endif
                  default: w_rd = '0;
               endcase
            end
         end
      end else begin
         case (reg_addr_i[2:0])
            3'd0:    w_rd = DATA_WIDTH'(r_en);
            3'd1:    w_rd = r_window;
            3'd2:    w_rd = r_thresh;
            3'd3:    w_rd = DATA_WIDTH'(r_irq_en);
            3'd4:    w_rd = DATA_WIDTH'(r_irq_status);
            3'd5:    w_rd = DATA_WIDTH'(r_win_count);
            default: w_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_input_q <= '0;
         r_ready   <= 1'b0;
         r_error   <= 1'b0;
         r_rdata   <= '0;
         r_irq     <= 1'b0;
         r_en      <= 1'b0;
         r_window  <= D_ONE;
         r_thresh  <= '0;
         r_irq_en  <= '0;
      end else begin
         r_input_q <= value_i;
         r_ready   <= w_acc;
         r_error   <= w_acc && w_err;
         r_irq     <= |(r_irq_status & r_irq_en);
         if (w_acc) r_rdata <= w_err ? ERR_W : w_rd;
         if (w_wr) begin
            if (reg_addr_i == ADDR_WIDTH'(0)) r_en     <= reg_wdata_i[0];
            if (reg_addr_i == ADDR_WIDTH'(1)) r_window <= reg_wdata_i;
            if (reg_addr_i == ADDR_WIDTH'(2)) r_thresh <= reg_wdata_i;
            if (reg_addr_i == ADDR_WIDTH'(3)) r_irq_en <= reg_wdata_i[NUM_CH-1:0];
         end
      end
   end

   // SCLR outranks a coincident window end; a hardware set outranks W1C.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= S_IDLE;
         r_shadow     <= '0;
         r_wcnt       <= '0;
         r_win_count  <= '0;
         r_irq_status <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_hit_acc[c] <= '0;
            r_bit_acc[c] <= '0;
            r_hits[c]    <= '0;
            r_bits[c]    <= '0;
         end
      end else if (w_sclr) begin
         r_state      <= reg_wdata_i[0] ? S_ARM : S_IDLE;
         r_wcnt       <= '0;
         r_win_count  <= '0;
         r_irq_status <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_hit_acc[c] <= '0;
            r_bit_acc[c] <= '0;
            r_hits[c]    <= '0;
            r_bits[c]    <= '0;
         end
      end else begin
         r_irq_status <= (r_irq_status & ~w_w1c) | w_set;
         case (r_state)
            S_IDLE: if (r_en) r_state <= S_ARM;
            S_ARM: begin
               r_state  <= r_en ? S_RUN : S_IDLE;
               r_wcnt   <= '0;
               r_shadow <= w_win_eff;
               for (int c = 0; c < NUM_CH; c++) begin
                  r_hit_acc[c] <= '0;
                  r_bit_acc[c] <= '0;
               end
            end
            S_RUN: begin
               if (!r_en) begin
                  r_state <= S_IDLE;
               end else if (w_wend) begin
                  r_wcnt      <= '0;
                  r_shadow    <= w_win_eff;
                  r_win_count <= (r_win_count == CMAX) ? CMAX : r_win_count + C_ONE;
                  for (int c = 0; c < NUM_CH; c++) begin
                     r_hits[c]    <= w_hit_nx[c];
                     r_bits[c]    <= w_bit_nx[c];
                     r_hit_acc[c] <= '0;
                     r_bit_acc[c] <= '0;
                  end
               end else begin
                  r_wcnt <= r_wcnt + D_ONE;
                  for (int c = 0; c < NUM_CH; c++) begin
                     r_hit_acc[c] <= w_hit_nx[c];
                     r_bit_acc[c] <= w_bit_nx[c];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
